// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the HD44780 character LCD driver: FSM states,
// register-word field positions, the power-on init sequence and the long-command test.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_PULSE    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_EXEC     = 3'd5
    } lcd_state_t;

    localparam int DATA_LSB = 0;
    localparam int RS_BIT   = 8;
    localparam int TOG_BIT  = 10;
    localparam int ON_BIT   = 31;

    localparam int INIT_LEN = 6;

    // Element 0 is sent first: function set x3, display on, entry mode, clear.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        8'h01, 8'h06, 8'h0C, 8'h38, 8'h38, 8'h38
    };

    // Clear display and return home need the long execution wait.
    function automatic logic is_long_cmd(input logic [7:0] data, input logic rs);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Down-counter used to time every LCD FSM state; done is raised while the count is 1.
module lcd_timer #(
    parameter int unsigned W        = 20,
    parameter int unsigned INIT_VAL = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] load_val,
    input  logic         load,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Holding at 1 keeps done asserted in untimed states without wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= W'(INIT_VAL);
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != W'(1)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 LCD driver: runs the power-on init sequence, then turns toggle-handshake
// requests from the LSU register word into timed write cycles on the LCD pins.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_POWERUP   = 750000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PULSE     = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic [31:0] o_lcd_status
);

    localparam int unsigned MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
    localparam int unsigned MAX_B = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
    localparam int unsigned MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned T_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int TW = $clog2(T_MAX + 1);

    lcd_state_t  state_reg, state_next;
    logic [7:0]  data_reg, data_next;
    logic        rs_reg, rs_next;
    logic        en_reg, en_next;
    logic        on_reg;
    logic        ack_tog_reg, ack_tog_next;
    logic        init_done_reg, init_done_next;
    logic [2:0]  init_idx_reg, init_idx_next;
    logic [31:0] status_reg, status_next;

    logic          pending;
    logic          timer_done;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          lcd_word_unused;

    assign pending         = (i_lcd_word[TOG_BIT] != ack_tog_reg);
    assign lcd_word_unused = ^{i_lcd_word[30:11], i_lcd_word[9]};

    lcd_timer #(
        .W        (TW),
        .INIT_VAL (T_POWERUP)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load_val (timer_val),
        .load     (timer_load),
        .done     (timer_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_PWR_WAIT;
            data_reg      <= 8'd0;
            rs_reg        <= 1'b0;
            en_reg        <= 1'b0;
            on_reg        <= 1'b0;
            ack_tog_reg   <= 1'b0;
            init_done_reg <= 1'b0;
            init_idx_reg  <= 3'd0;
            status_reg    <= 32'h1;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            rs_reg        <= rs_next;
            en_reg        <= en_next;
            on_reg        <= i_lcd_word[ON_BIT];
            ack_tog_reg   <= ack_tog_next;
            init_done_reg <= init_done_next;
            init_idx_reg  <= init_idx_next;
            status_reg    <= status_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PWR_WAIT: if (timer_done) state_next = ST_SETUP;
            ST_IDLE:     if (pending)    state_next = ST_SETUP;
            ST_SETUP:    if (timer_done) state_next = ST_PULSE;
            ST_PULSE:    if (timer_done) state_next = ST_HOLD;
            ST_HOLD:     if (timer_done) state_next = ST_EXEC;
            ST_EXEC: begin
                if (timer_done) begin
                    if (!init_done_reg && (init_idx_reg < 3'(INIT_LEN - 1)))
                        state_next = ST_SETUP;
                    else
                        state_next = ST_IDLE;
                end
            end
            default:     state_next = ST_PWR_WAIT;
        endcase
    end

    always_comb begin
        data_next      = data_reg;
        rs_next        = rs_reg;
        ack_tog_next   = ack_tog_reg;
        init_done_next = init_done_reg;
        init_idx_next  = init_idx_reg;
        case (state_reg)
            ST_PWR_WAIT: begin
                if (timer_done) begin
                    init_idx_next = 3'd0;
                    data_next     = INIT_ROM[init_idx_next];
                    rs_next       = 1'b0;
                end
            end
            ST_IDLE: begin
                if (pending) begin
                    data_next    = i_lcd_word[DATA_LSB +: 8];
                    rs_next      = i_lcd_word[RS_BIT];
                    ack_tog_next = i_lcd_word[TOG_BIT];
                end
            end
            ST_EXEC: begin
                if (timer_done && !init_done_reg) begin
                    if (init_idx_reg < 3'(INIT_LEN - 1)) begin
                        init_idx_next = init_idx_reg + 3'd1;
                        data_next     = INIT_ROM[init_idx_next];
                        rs_next       = 1'b0;
                    end else begin
                        init_done_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        en_next     = (state_next == ST_PULSE);
        status_next = {29'd0, ack_tog_next, init_done_next, state_next != ST_IDLE};
    end

    // Every state is timed from entry; the EXEC length follows the byte being written.
    always_comb begin
        timer_load = (state_next != state_reg);
        timer_val  = TW'(1);
        case (state_next)
            ST_PWR_WAIT: timer_val = TW'(T_POWERUP);
            ST_SETUP:    timer_val = TW'(T_SETUP);
            ST_PULSE:    timer_val = TW'(T_PULSE);
            ST_HOLD:     timer_val = TW'(T_HOLD);
            ST_EXEC:     timer_val = is_long_cmd(data_reg, rs_reg) ? TW'(T_EXEC_LONG) : TW'(T_EXEC);
            default:     timer_val = TW'(1);
        endcase
    end

    assign o_lcd_data   = data_reg;
    assign o_lcd_rs     = rs_reg;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = en_reg;
    assign o_lcd_on     = on_reg;
    assign o_lcd_status = status_reg;

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware driver for the board's HD44780-compatible character LCD, sitting on the far side of the LSU's memory-mapped LCD register. It takes the 32-bit LCD register word and runs the power-on initialisation sequence on its own. It then converts each software request into a correctly timed write cycle on the LCD pins (setup, enable pulse, hold, execution wait), so software no longer bit-bangs EN. A status word is returned for the LSU read mux so software can poll for completion.

## Interface
- T_POWERUP, 750000: cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2: cycles that data/RS are stable before EN rises.
- T_PULSE, 12: EN high width, in cycles.
- T_HOLD, 2: cycles that data/RS are held after EN falls.
- T_EXEC, 2000: execution wait for normal commands and data (40 us).
- T_EXEC_LONG, 82000: execution wait for clear/home (1.64 ms).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lcd_word  in  32  LCD register from the LSU. Fields:
  - [7:0] data.
  - [8] RS.
  - [9] reserved, ignored.
  - [10] request toggle.
  - [31] display power.
  - All other bits ignored.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW; constant 0, write-only.
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  LCD backlight/power.
- o_lcd_status  out  32  status word:
  - bit0 busy.
  - bit1 init_done.
  - bit2 ack_tog, the toggle value last accepted.
  - Other bits 0.

## Operation
- Request protocol: a request is pending when i_lcd_word[10] != ack_tog. Software flips bit 10 together with the new data/RS in a single store.
- The pending check is sampled only in IDLE. At accept, ack_tog <= word[10], and data/RS are latched into the output registers.
- States:
  - PWR_WAIT: count T_POWERUP, then go to SETUP with init index 0.
  - IDLE: move to SETUP on a pending request.
  - SETUP: T_SETUP cycles, then PULSE.
  - PULSE: EN=1 for T_PULSE cycles, then HOLD.
  - HOLD: T_HOLD cycles, then EXEC.
  - EXEC: T_EXEC or T_EXEC_LONG cycles.
- EXEC exit:
  - During init, if index < 5: increment the index and go to SETUP with the next init byte.
  - On completing index 5: set init_done=1 and go to IDLE.
  - Otherwise go to IDLE.
- Init sequence, RS=0: 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01.
- Long wait selection: RS=0 and data[7:2]==0 (0x01, 0x02 or 0x03) select T_EXEC_LONG; all other transfers use T_EXEC.
- busy = (state != IDLE). This includes PWR_WAIT and the init sequence.
- o_lcd_on <= i_lcd_word[31], registered every cycle regardless of state.
- Toggle changes while busy are not queued. Only the word present at the first IDLE cycle is served, using its latest data/RS. Two flips during busy cancel, and no transaction occurs.
- A toggle mismatch present when init completes is served immediately from IDLE.
- Reset values: data=0, rs=0, rw=0, en=0, on=0, state=PWR_WAIT, ack_tog=0, init_done=0. o_lcd_status reads 0x1 during reset (busy).
- Reset mid-transfer: EN drops immediately (asynchronous) and the full init sequence restarts.

## Timing
- Let A be the clock edge at which IDLE sees a pending request. Relative to A:
  - After A: busy=1, data/RS valid.
  - EN rises at A+T_SETUP and falls at A+T_SETUP+T_PULSE.
  - Data held through A+T_SETUP+T_PULSE+T_HOLD.
  - busy falls at A+T_SETUP+T_PULSE+T_HOLD+T_EXEC(_LONG).
- Back-to-back: with the toggle already flipped at the busy fall edge, the next accept happens on the following edge (1 idle cycle).
- Timer: a single down-counter, width $clog2 of the largest parameter, loaded on every state entry. A state exits when the count reaches 1, so each state lasts exactly its parameter value. All parameters must be ≥1.
- All outputs are registered with no combinational paths from i_lcd_word. o_lcd_status is registered.

## Structure
- lcd_ctrl_pkg holds:
  - The state enum.
  - Field bit positions (DATA_LSB, RS_BIT, TOG_BIT, ON_BIT).
  - The 6-entry init ROM constant array.
  - The long-command predicate as a function.
- Sub-module lcd_timer: load value, load strobe, and a done flag.

## Test plan
Use sim parameters T_POWERUP=20, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=30.
- Reset then idle word 0:
  - busy=1 for 20 cycles.
  - Then exactly six EN pulses with data 38, 38, 38, 0C, 06, 01 and RS=0.
  - The last exec lasts 30 cycles, after which status=0x2.
- After init, write 0x8000_0541:
  - Next cycle: data=0x41, rs=1, on=1.
  - EN high edges A+2 to A+6.
  - busy falls at A+18; status=0x6.
- Then write 0x0000_0001 (toggle back to 0):
  - RS=0, data=0x01.
  - busy lasts 38 cycles, using the long wait.
- While busy, flip toggle with data 0x42, then change data to 0x43 with no further flip:
  - After busy falls, exactly one transfer of 0x43.
  - A second case flips the toggle twice during busy: no transfer.
- Assert i_rst_n=0 while EN=1:
  - EN=0 and status=0x1 immediately.
  - After release, the full 20-cycle wait and init sequence repeat.
- Flip the toggle during PWR_WAIT with data 0x55, RS=1:
  - Init completes unchanged.
  - Then 0x55 is written on the first IDLE cycle.
